// File: rtl/dotproduct_pkg.sv
// -----------------------------------------------------------------------------
// dotproduct_pkg
//   Shared definitions for the embedding dot-product datapath: the 4-element
//   chunk stage upstream and the dot_accumulator that sums its results.
//
//   CHUNK_W      : width of one signed chunk dot-product result (16)
//   ELEM_W       : width of one signed vector element (5)
//   acc_state_t  : accumulator control states
// -----------------------------------------------------------------------------
package dotproduct_pkg;

  localparam int CHUNK_W = 16;
  localparam int ELEM_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage : dotproduct_pkg

// File: rtl/dot_accumulator.sv
// -----------------------------------------------------------------------------
// dot_accumulator
//   Sums NUM_CHUNKS signed chunk dot products into one signed ACC_W-bit
//   embedding dot product, flags wrap-around, and compares the total against
//   a threshold captured when the accumulation starts.
//
//   Parameters
//     NUM_CHUNKS : chunk results per embedding (2..256)
//     ACC_W      : accumulator / threshold width, signed (>= 17)
//
//   Ports
//     clk, rst_n : clock, asynchronous active-low reset
//     start      : begin a new accumulation (honoured only in IDLE)
//     threshold  : signed match threshold, captured with start
//     in_valid   : in_result carries a chunk result
//     in_ready   : a chunk can be accepted this cycle (ACCUM only)
//     in_result  : signed chunk dot product
//     out_valid  : out_sum / out_match / overflow are valid (DONE only)
//     out_ready  : consumer takes the result
//     out_sum    : signed embedding dot product
//     out_match  : out_sum >= captured threshold
//     overflow   : accumulator wrapped during this embedding (sticky)
//     busy       : block is not IDLE
// -----------------------------------------------------------------------------
module dot_accumulator
  import dotproduct_pkg::*;
#(
  parameter int NUM_CHUNKS = 8,
  parameter int ACC_W      = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ACC_W-1:0]   threshold,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_match,
  output logic               overflow,
  output logic               busy
);

  // Sized one past the largest index so the count can never wrap inside an
  // embedding, even at NUM_CHUNKS = 256.
  localparam int                CNT_W    = $clog2(NUM_CHUNKS + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

  acc_state_t               state;
  acc_state_t               state_next;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  thr_q;
  logic signed [ACC_W-1:0]  chunk_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]         count;

  logic                     start_ok;
  logic                     accept;
  logic                     last_accept;
  logic                     add_ovf;

  // Handshake outputs decode the state register only, so there is no
  // combinational path from in_valid or out_ready to any output.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign start_ok    = (state == IDLE) && start;
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (count == LAST_IDX);

  assign chunk_ext = {{(ACC_W - CHUNK_W){in_result[CHUNK_W-1]}}, in_result};
  assign acc_sum   = acc + chunk_ext;

  // Two's-complement overflow: operands agree in sign, result does not.
  assign add_ovf = (acc[ACC_W-1] == chunk_ext[ACC_W-1]) &&
                   (acc_sum[ACC_W-1] != acc[ACC_W-1]);

  // NOTE: state lives in the reset domain with an async clear; every
  // sequential assignment is non-blocking so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: defaults first, so every path assigns state_next and no latch forms.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)       state_next = ACCUM;
      ACCUM:   if (last_accept) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Datapath. Results are written only on the final accept, so they hold
  // through DONE and stay at their last value in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      thr_q     <= '0;
      out_sum   <= '0;
      out_match <= 1'b0;
      overflow  <= 1'b0;
    end else if (start_ok) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      thr_q    <= threshold;
    end else if (accept) begin
      acc   <= acc_sum;
      count <= count + CNT_W'(1);
      if (add_ovf) begin
        overflow <= 1'b1;
      end
      if (last_accept) begin
        out_sum   <= acc_sum;
        out_match <= (acc_sum >= thr_q);
      end
    end
  end

endmodule : dot_accumulator

// File: tb/tb_dot_accumulator.sv
// -----------------------------------------------------------------------------
// tb_dot_accumulator
//   Self-checking bench for dot_accumulator. One instance uses the default
//   parameters (8 chunks, 24-bit); a second uses ACC_W = 17 to exercise
//   wrap-around. Expected values come from a plain-arithmetic model of the
//   embedding sum (running total kept in a longint, wrapped into the signed
//   ACC_W range whenever it leaves it).
// -----------------------------------------------------------------------------
module tb_dot_accumulator;

  logic        clk;
  logic        rst_n;

  // default instance
  logic        start;
  logic [23:0] threshold;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic        out_match;
  logic        overflow;
  logic        busy;

  // 17-bit instance
  logic        start17;
  logic [16:0] threshold17;
  logic        in_valid17;
  logic        in_ready17;
  logic [15:0] in_result17;
  logic        out_valid17;
  logic        out_ready17;
  logic [16:0] out_sum17;
  logic        out_match17;
  logic        overflow17;
  logic        busy17;

  int n_checks = 0;
  int n_pass   = 0;

  dot_accumulator #(.NUM_CHUNKS(8), .ACC_W(24)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .threshold (threshold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_match (out_match),
    .overflow  (overflow),
    .busy      (busy)
  );

  dot_accumulator #(.NUM_CHUNKS(8), .ACC_W(17)) u_dut17 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start17),
    .threshold (threshold17),
    .in_valid  (in_valid17),
    .in_ready  (in_ready17),
    .in_result (in_result17),
    .out_valid (out_valid17),
    .out_ready (out_ready17),
    .out_sum   (out_sum17),
    .out_match (out_match17),
    .overflow  (overflow17),
    .busy      (busy17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed sum wrapped into ACC_W bits, overflow if the running
  // total ever left the representable range, match against the captured
  // threshold.
  function automatic void ref_embed(input int vals[8], input int w, input longint thr_s,
                                    output longint sum, output bit ovf, output bit match);
    longint span = longint'(1) << w;
    longint hi   = (longint'(1) << (w - 1)) - 1;
    longint lo   = -(longint'(1) << (w - 1));
    sum = 0;
    ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sum += longint'(vals[i]);
      if (sum > hi) begin
        sum -= span;
        ovf = 1'b1;
      end else if (sum < lo) begin
        sum += span;
        ovf = 1'b1;
      end
    end
    match = (sum >= thr_s);
  endfunction

  // One full embedding on the 24-bit instance.
  //   mode 0: in_valid held, 1: toggling 1,0,1,..., 2: random with stray starts
  //   hold  : cycles out_ready stays low in DONE
  task automatic run_embed(input int vals[8], input logic [23:0] thr, input int mode,
                           input int hold, input bit thr_mid_zero);
    longint    exp_sum;
    bit        exp_ovf;
    bit        exp_match;
    int        idx;
    int        cyc;
    bit        v;
    bit        took;
    logic [63:0] exp_bits;

    ref_embed(vals, 24, longint'($signed(thr)), exp_sum, exp_ovf, exp_match);
    exp_bits = 64'(exp_sum) & 64'hFF_FFFF;

    @(negedge clk);
    start     = 1'b1;
    threshold = thr;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("in_ready_in_accum", in_ready, 1'b1);

    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid  = v;
      in_result = v ? 16'(vals[idx]) : 16'($urandom);
      if (thr_mid_zero && idx == 4) threshold = '0;
      if (mode == 2) begin
        start = 1'($urandom_range(0, 1));
        if (start) threshold = 24'($urandom);
      end
      took = v && in_ready;
      if (took && idx == 7) check("no_valid_before_last", out_valid, 1'b0);
      @(negedge clk);
      if (took) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check("accept_count", 64'(idx), 64'd8);

    // One cycle after the last accept.
    check("out_valid_latency", out_valid, 1'b1);
    check("in_ready_in_done", in_ready, 1'b0);
    check("out_sum", out_sum, exp_bits);
    check("out_match", out_match, exp_match);
    check("overflow", overflow, exp_ovf);

    for (int k = 0; k < hold; k++) begin
      start     = (k % 2 == 0);
      threshold = 24'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_sum", out_sum, exp_bits);
      check("hold_match", out_match, exp_match);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_dropped", out_valid, 1'b0);
    check("idle_not_busy", busy, 1'b0);
    check("idle_keeps_sum", out_sum, exp_bits);
  endtask

  int v_base[8] = '{10, 20, -5, 0, 30, 15, 25, 10};
  int v_rnd[8];

  initial begin
    int     n;
    int     cyc;
    bit     took;
    bit     saw_valid;
    longint s;
    bit     o;
    bit     m;

    rst_n       = 1'b1;
    start       = 1'b0;
    threshold   = '0;
    in_valid    = 1'b0;
    in_result   = '0;
    out_ready   = 1'b0;
    start17     = 1'b0;
    threshold17 = '0;
    in_valid17  = 1'b0;
    in_result17 = '0;
    out_ready17 = 1'b0;

    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_sum", out_sum, 24'd0);
    check("rst_overflow", overflow, 1'b0);
    #14 rst_n = 1'b1;

    // Directed: threshold 100 -> match; 106 -> no match; 106 then live 0.
    run_embed(v_base, 24'd100, 0, 0, 1'b0);
    run_embed(v_base, 24'd106, 0, 0, 1'b0);
    run_embed(v_base, 24'd106, 0, 0, 1'b1);
    // Toggling in_valid and a 5-cycle stall in DONE with stray starts.
    run_embed(v_base, 24'd50, 1, 5, 1'b0);

    // Wrap-around on the 17-bit instance: 8 x 16383.
    @(negedge clk);
    start17     = 1'b1;
    threshold17 = '0;
    @(negedge clk);
    start17     = 1'b0;
    in_valid17  = 1'b1;
    in_result17 = 16'd16383;
    n   = 0;
    cyc = 0;
    while (n < 8 && cyc < 100) begin
      took = in_valid17 && in_ready17;
      @(negedge clk);
      if (took) n++;
      cyc++;
    end
    in_valid17 = 1'b0;
    check("w17_accept_count", 64'(n), 64'd8);
    check("w17_out_valid", out_valid17, 1'b1);
    check("w17_out_sum", out_sum17, 17'd131064);
    check("w17_overflow", overflow17, 1'b1);
    check("w17_out_match", out_match17, 1'b0);
    out_ready17 = 1'b1;
    @(negedge clk);
    out_ready17 = 1'b0;
    check("w17_idle", busy17, 1'b0);

    // Reset in the middle of an accumulation after 3 chunks.
    @(negedge clk);
    start     = 1'b1;
    threshold = 24'd7;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 50) begin
      in_result = 16'(v_base[n]);
      took = in_valid && in_ready;
      @(negedge clk);
      if (took) n++;
      cyc++;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_sum", out_sum, 24'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    #8 rst_n = 1'b1;
    saw_valid = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid || busy) saw_valid = 1'b1;
    end
    in_valid = 1'b0;
    check("midrst_no_result", saw_valid, 1'b0);

    run_embed(v_base, 24'd105, 0, 0, 1'b0);

    // Random embeddings with thresholds at or next to the true sum.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) v_rnd[i] = int'($urandom_range(0, 65535)) - 32768;
      ref_embed(v_rnd, 24, 0, s, o, m);
      run_embed(v_rnd, 24'(s + longint'($urandom_range(0, 2)) - 1), 2, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_dot_accumulator
